// File: rtl/sprite_mem_arbiter.sv
// sprite_mem_arbiter
// Shares the single-port sprite memory between the CPU data bus and the VGA
// sprite fetch unit. Video fetch normally wins a conflict. A saturating wait
// counter lets the CPU win once it has lost MAX_WAIT conflicts in a row.
// Read data returns one cycle after the grant. It is steered to whichever
// requester issued that read.

module sprite_mem_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_gnt,
   output logic              vid_rvalid,
   output logic [DATA_W-1:0] vid_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_VID  = 2'd2
   } ownerT;

   localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

   logic [3:0] waitCnt_q;
   logic [3:0] waitCnt_d;
   ownerT      rdOwner_q;
   ownerT      rdOwner_d;
   logic       cpuStarved;
   logic       cpuGnt;
   logic       vidGnt;

   assign cpuStarved = (waitCnt_q == MaxWait);

   // Pick at most one winner per cycle; reset blocks every grant so nothing reaches memory
   always_comb begin
      cpuGnt = 1'b0;
      vidGnt = 1'b0;
      if (!reset) begin
         if (cpu_req && (!vid_req || cpuStarved)) begin
            cpuGnt = 1'b1;
         end else if (vid_req) begin
            vidGnt = 1'b1;
         end
      end
   end

   // Count consecutive lost cycles of a pending CPU request, saturating at MAX_WAIT
   always_comb begin
      waitCnt_d = waitCnt_q;
      if (!cpu_req || cpuGnt) begin
         waitCnt_d = 4'd0;
      end else if (waitCnt_q < MaxWait) begin
         waitCnt_d = waitCnt_q + 4'd1;
      end
   end

   // Wait counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         waitCnt_q <= 4'd0;
      end else begin
         waitCnt_q <= waitCnt_d;
      end
   end

   // Read-owner state register; reset discards any read that is in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         rdOwner_q <= OWN_NONE;
      end else begin
         rdOwner_q <= rdOwner_d;
      end
   end

   // Tag the next cycle's returning data with the requester whose read was granted now
   always_comb begin
      rdOwner_d = OWN_NONE;
      if (cpuGnt && !cpu_we) begin
         rdOwner_d = OWN_CPU;
      end else if (vidGnt) begin
         rdOwner_d = OWN_VID;
      end
   end

   // Read-return outputs decoded from the owner tag
   always_comb begin
      cpu_rvalid = (rdOwner_q == OWN_CPU);
      vid_rvalid = (rdOwner_q == OWN_VID);
      cpu_rdata  = mem_rdata;
      vid_rdata  = mem_rdata;
   end

   // Route the winning requester onto the memory port; park the port at zero when idle
   always_comb begin
      mem_en    = cpuGnt | vidGnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpuGnt) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (vidGnt) begin
         mem_addr  = vid_addr;
      end
   end

   assign cpu_gnt = cpuGnt;
   assign vid_gnt = vidGnt;

endmodule

// File: doc/sprite_mem_arbiter.md
# sprite_mem_arbiter

Two-requester arbiter sharing the single-port sprite memory between the CPU data bus (write/read, after address decode selects sprite space) and the VGA sprite fetch unit (read-only). Video fetch has priority to keep the display pipeline fed. A bounded-wait counter guarantees CPU progress. Read data returns one cycle after grant and is steered to the requester that issued the read.

## Interface
- ADDR_W, 12, sprite memory word-address width
- DATA_W, 32, data width
- MAX_WAIT, 3, consecutive conflict cycles the CPU may lose before it wins the next conflict (1..15)

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request (qualified by decoder's sprite_mem_enable)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_rvalid  out  1  cpu_rdata valid
- cpu_rdata  out  DATA_W  read data to CPU
- vid_req  in  1  video fetch read request
- vid_addr  in  ADDR_W  video word address
- vid_gnt  out  1  video access accepted this cycle
- vid_rvalid  out  1  vid_rdata valid
- vid_rdata  out  DATA_W  read data to video
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, synchronous, valid one cycle after mem_en with mem_we=0

## Operation
- Handshake: requester holds req, we, addr, wdata stable until it samples gnt=1 at a rising edge; one gnt = one accepted access. Requester may deassert req only after gnt.
- Arbitration (combinational, per cycle, at most one gnt):
  - only cpu_req: cpu_gnt=1.
  - only vid_req: vid_gnt=1.
  - both: vid_gnt=1 unless wait_cnt == MAX_WAIT, then cpu_gnt=1.
  - neither: no grant, mem_en=0.
- wait_cnt (4-bit, registered): increments when cpu_req=1 and cpu_gnt=0; saturates at MAX_WAIT; clears to 0 when cpu_gnt=1 or cpu_req=0.
- Memory mux: mem_en = cpu_gnt | vid_gnt; mem_addr/mem_wdata/mem_we from granted requester; mem_we = cpu_gnt & cpu_we (video never writes). With no grant: mem_addr=0, mem_wdata=0, mem_we=0.
- Read return: registered tag rd_owner {NONE, CPU, VID} set at edge after a granted read (CPU with cpu_we=0, or video); NONE after a write or idle cycle.
  - cpu_rvalid = (rd_owner==CPU); vid_rvalid = (rd_owner==VID).
  - cpu_rdata and vid_rdata both driven from mem_rdata; valid only while matching rvalid.
- CPU writes produce no rvalid.

## Timing
- Grant latency 0: gnt same cycle as req when arbitration allows.
- Read latency: rvalid exactly 1 cycle after the gnt cycle; back-to-back reads from either or alternating requesters give one rvalid per cycle, no bubbles.
- Worst-case CPU wait under continuous vid_req: MAX_WAIT lost cycles, granted on cycle MAX_WAIT+1 after first request.
- Reset (while reset=1, sampled at edge): wait_cnt=0, rd_owner=NONE. Grants forced 0 combinationally while reset=1, so mem_en=0, mem_we=0, cpu_gnt=vid_gnt=0, cpu_rvalid=vid_rvalid=0 from the first reset edge onward.
- Reset mid-read: read granted in cycle N, reset asserted in N: the N+1 rvalid is suppressed; data discarded.
- Simultaneous CPU write and wait_cnt saturation: write wins, video retries next cycle; video read in flight from prior cycle still returns its rvalid in this cycle.

## Test plan
- Reset: hold reset 2 cycles with cpu_req=vid_req=1 -> all gnt/rvalid/mem_en=0; after release, vid_gnt=1 on first cycle.
- CPU-only write addr 0x010 data 0xDEADBEEF, then read 0x010 -> cpu_gnt each cycle, mem_we=1 then 0, cpu_rvalid=1 next cycle with cpu_rdata=0xDEADBEEF, vid_rvalid=0.
- Continuous vid_req plus cpu_req read 0x020, MAX_WAIT=3 -> vid_gnt cycles 0-2, cpu_gnt at cycle 3, wait_cnt 0,1,2,3,0; cpu_rvalid at cycle 4.
- Alternating video reads 0x001, 0x002 and CPU read 0x003 without gaps -> rvalid each cycle tagged to correct owner, data matches preloaded memory.
- Reset asserted in the cycle of a granted video read -> vid_rvalid stays 0 next cycle.
- cpu_req dropped after 2 lost cycles then reasserted -> wait_cnt restarts from 0; CPU waits full MAX_WAIT again.
